// File: rtl/gray_tracker.sv
// Gray-coded position tracker: converts samples to binary, classifies moves, and accumulates
// position. Define GRAY_TRACK_LAP_EN to add the Laps port and its lap counter.
module gray_tracker #(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned POS_WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 En,
  input  logic [WIDTH-1:0]     Gray,
  input  logic                 Clear,
  output logic [WIDTH-1:0]     Binary,
  output logic [POS_WIDTH-1:0] Position,
  output logic                 Dir,
  output logic                 Step,
`ifdef GRAY_TRACK_LAP_EN
  output logic [7:0]           Laps,
`endif
  output logic                 Error
);

  typedef enum logic [1:0] {StIdle, StTrack, StFault} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     prev_q, prev_d;
  logic [WIDTH-1:0]     binary_q, binary_d;
  logic [POS_WIDTH-1:0] position_q, position_d;
  logic                 dir_q, dir_d;
  logic                 step_q, step_d;
  logic [WIDTH-1:0]     bin;
  logic [WIDTH-1:0]     diff;
  logic                 is_fwd, is_bwd;
`ifdef GRAY_TRACK_LAP_EN
  logic [7:0]           laps_q, laps_d;
`endif

  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_conv
    assign bin[i] = ^(Gray >> i);
  end

  assign diff   = bin - prev_q;
  assign is_fwd = (diff == WIDTH'(1));
  assign is_bwd = (diff == {WIDTH{1'b1}});

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      prev_q     <= '0;
      binary_q   <= '0;
      position_q <= '0;
      dir_q      <= 1'b0;
      step_q     <= 1'b0;
`ifdef GRAY_TRACK_LAP_EN
      laps_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      binary_q   <= binary_d;
      position_q <= position_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
`ifdef GRAY_TRACK_LAP_EN
      laps_q     <= laps_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    binary_d   = binary_q;
    position_d = position_q;
    dir_d      = dir_q;
    step_d     = 1'b0;
`ifdef GRAY_TRACK_LAP_EN
    laps_d     = laps_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (En) begin
          prev_d   = bin;
          binary_d = bin;
          state_d  = StTrack;
        end
      end
      StTrack: begin
        if (En) begin
          binary_d = bin;
          if (is_fwd) begin
            position_d = position_q + POS_WIDTH'(1);
            dir_d      = 1'b1;
            step_d     = 1'b1;
            prev_d     = bin;
`ifdef GRAY_TRACK_LAP_EN
            if (prev_q == {WIDTH{1'b1}} && bin == '0) laps_d = laps_q + 8'd1;
`endif
          end else if (is_bwd) begin
            position_d = position_q - POS_WIDTH'(1);
            dir_d      = 1'b0;
            step_d     = 1'b1;
            prev_d     = bin;
`ifdef GRAY_TRACK_LAP_EN
            if (prev_q == '0 && bin == {WIDTH{1'b1}}) laps_d = laps_q - 8'd1;
`endif
          end else if (diff != '0) begin
            state_d = StFault;
          end
        end
      end
      StFault: begin
        // Clear wins over a simultaneous sample; that sample is dropped.
        if (Clear) begin
          state_d = StIdle;
        end else if (En) begin
          binary_d = bin;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    Binary   = binary_q;
    Position = position_q;
    Dir      = dir_q;
    Step     = step_q;
    Error    = (state_q == StFault);
`ifdef GRAY_TRACK_LAP_EN
    Laps     = laps_q;
`endif
  end

endmodule
